regfile_wb_queue: RTL and testbench

- Write-side initiator for the CPU register file. Drives the file's WriteRegister, WriteData and RegWrite inputs.
- Merges two writeback sources:
  - the single-cycle primary pipeline writeback (default priority);
  - a valid/ready stream from multi-cycle producers (load unit, multiplier), buffered in a small FIFO.
- Presents at most one registered write per cycle to the register file.

---
 rtl/regfile_wb_queue.sv | 169 ++++++++++++++++
 tb/tb_regfile_wb_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Write-side initiator for the CPU register file. Merges the single-cycle
//   primary writeback with a buffered valid/ready stream from multi-cycle
//   producers. At most one registered write reaches the register file per cycle.
//
//   Parameters
//     DEPTH        FIFO entries (power of 2, >= 2)
//     STARVE_LIMIT consecutive blocked cycles before the queue forces PriStall
//
//   Ports
//     Clk, Reset_n                     clock, asynchronous active-low reset
//     PriRegWrite/PriWriteRegister/PriWriteData  primary writeback request
//     PriStall                         primary write ignored; pipeline must hold
//     ReqValid/ReqReady/ReqRegister/ReqData      queued writeback stream
//     RegWrite/WriteRegister/WriteData registered write port to the register file
//     Count/Empty/Full                 queue occupancy
//
//   Optional build macro WB_FORWARD_EN adds two combinational lookup ports
//   (LookupRegisterN -> LookupHitN/LookupDataN) returning the youngest pending
//   value for a register: youngest queued entry first, then the output stage.
module regfile_wb_queue #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       PriRegWrite,
  input  logic [4:0]                 PriWriteRegister,
  input  logic [31:0]                PriWriteData,
  output logic                       PriStall,
  input  logic                       ReqValid,
  output logic                       ReqReady,
  input  logic [4:0]                 ReqRegister,
  input  logic [31:0]                ReqData,
  output logic                       RegWrite,
  output logic [4:0]                 WriteRegister,
  output logic [31:0]                WriteData,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty,
  output logic                       Full
`ifdef WB_FORWARD_EN
  ,
  input  logic [4:0]                 LookupRegister1,
  input  logic [4:0]                 LookupRegister2,
  output logic                       LookupHit1,
  output logic                       LookupHit2,
  output logic [31:0]                LookupData1,
  output logic [31:0]                LookupData2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       memReg  [DEPTH];
  logic [31:0]      memData [DEPTH];
  logic [PTR_W-1:0] rdPtrReg;
  logic [PTR_W-1:0] wrPtrReg;
  logic [CNT_W-1:0] countReg;
  logic [STV_W-1:0] starveReg;

  logic pushEn;
  logic priReq;
  logic popEn;

  assign Count    = countReg;
  assign Empty    = (countReg == '0);
  assign Full     = (countReg == CNT_W'(DEPTH));
  assign ReqReady = !Full;
  // Derived from registered state only, so the pipeline sees no path from
  // its own request back into the stall.
  assign PriStall = (starveReg == STV_W'(STARVE_LIMIT)) && !Empty;

  // Writes to x0 are dropped: accepted on the stream, no-op on the primary.
  assign pushEn = ReqValid && ReqReady && (ReqRegister != 5'd0);
  assign priReq = PriRegWrite && (PriWriteRegister != 5'd0);
  // Queue head goes out when it is forcing a stall or when the primary is idle.
  assign popEn  = !Empty && (PriStall || !priReq);

  // Storage has no reset so it maps onto plain RAM; the output stage below
  // acts as its registered read port.
  always_ff @(posedge Clk) begin
    if (pushEn) begin
      memReg[wrPtrReg]  <= ReqRegister;
      memData[wrPtrReg] <= ReqData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wrPtrReg  <= '0;
      rdPtrReg  <= '0;
      countReg  <= '0;
      starveReg <= '0;
    end else begin
      if (pushEn) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (popEn)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      case ({pushEn, popEn})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
      if (Empty || popEn)
        starveReg <= '0;
      else if (starveReg != STV_W'(STARVE_LIMIT))
        starveReg <= starveReg + STV_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (popEn) begin
      RegWrite      <= 1'b1;
      WriteRegister <= memReg[rdPtrReg];
      WriteData     <= memData[rdPtrReg];
    end else if (priReq) begin
      RegWrite      <= 1'b1;
      WriteRegister <= PriWriteRegister;
      WriteData     <= PriWriteData;
    end else begin
      // Address/data hold their last values while idle.
      RegWrite      <= 1'b0;
    end
  end

`ifdef WB_FORWARD_EN
  for (genvar gi = 0; gi < 2; gi++) begin : gLookup
    logic [4:0]  key;
    logic        hit;
    logic [31:0] data;

    assign key = (gi == 0) ? LookupRegister1 : LookupRegister2;

    // Scan oldest to youngest so the youngest match overrides; the output
    // stage is older than anything still queued.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      if (RegWrite && (WriteRegister == key)) begin
        hit  = 1'b1;
        data = WriteData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < countReg) && (memReg[rdPtrReg + PTR_W'(i)] == key)) begin
          hit  = 1'b1;
          data = memData[rdPtrReg + PTR_W'(i)];
        end
      end
      if (key == 5'd0) begin
        hit  = 1'b0;
        data = '0;
      end
    end

    if (gi == 0) begin : gPort1
      assign LookupHit1  = hit;
      assign LookupData1 = data;
    end else begin : gPort2
      assign LookupHit2  = hit;
      assign LookupData2 = data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue
//   Randomised and directed stimulus against a queue-based reference model.
//   The model predicts, per clock edge, which write the register file should
//   receive; a separate monitor pops those predictions and compares them with
//   the DUT output stage and occupancy flags on the falling edge.
//   Build with +define+WB_FORWARD_EN to also exercise the lookup ports.
module tb_regfile_wb_queue;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } WbEntry;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             PriRegWrite = 1'b0;
  logic [4:0]       PriWriteRegister = '0;
  logic [31:0]      PriWriteData = '0;
  logic             PriStall;
  logic             ReqValid = 1'b0;
  logic             ReqReady;
  logic [4:0]       ReqRegister = '0;
  logic [31:0]      ReqData = '0;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [31:0]      WriteData;
  logic [CNT_W-1:0] Count;
  logic             Empty;
  logic             Full;
`ifdef WB_FORWARD_EN
  logic [4:0]       LookupRegister1 = '0;
  logic [4:0]       LookupRegister2 = '0;
  logic             LookupHit1;
  logic             LookupHit2;
  logic [31:0]      LookupData1;
  logic [31:0]      LookupData2;
`endif

  regfile_wb_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .PriRegWrite(PriRegWrite), .PriWriteRegister(PriWriteRegister),
    .PriWriteData(PriWriteData), .PriStall(PriStall),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqRegister(ReqRegister), .ReqData(ReqData),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Count(Count), .Empty(Empty), .Full(Full)
`ifdef WB_FORWARD_EN
    ,
    .LookupRegister1(LookupRegister1), .LookupRegister2(LookupRegister2),
    .LookupHit1(LookupHit1), .LookupHit2(LookupHit2),
    .LookupData1(LookupData1), .LookupData2(LookupData2)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  WbEntry      modelQ[$];
  WbEntry      expQ[$];
  int          starve = 0;
  logic [4:0]  lastR = '0;
  logic [31:0] lastD = '0;
  bit          curValid = 0;

  task automatic modelReset();
    modelQ.delete();
    expQ.delete();
    starve   = 0;
    lastR    = '0;
    lastD    = '0;
    curValid = 0;
  endtask

  // Decide what the register file sees after this edge, from the rules:
  // forced stall pops, else a real primary write wins, else the queue drains.
  always @(posedge Clk) begin
    int     sz;
    bit     stall;
    bit     pri;
    bit     popped;
    WbEntry e;
    if (Reset_n) begin
      sz     = modelQ.size();
      stall  = (starve == STARVE_LIMIT) && (sz > 0);
      pri    = PriRegWrite && (PriWriteRegister != 5'd0);
      popped = 0;
      if (stall) begin
        e = modelQ.pop_front(); expQ.push_back(e); popped = 1;
      end else if (pri) begin
        e.r = PriWriteRegister; e.d = PriWriteData; expQ.push_back(e);
      end else if (sz > 0) begin
        e = modelQ.pop_front(); expQ.push_back(e); popped = 1;
      end
      if (ReqValid && (sz < DEPTH) && (ReqRegister != 5'd0)) begin
        e.r = ReqRegister; e.d = ReqData; modelQ.push_back(e);
      end
      if (sz == 0 || popped) starve = 0;
      else if (starve < STARVE_LIMIT) starve = starve + 1;
    end
  end

  // Monitor: one transaction line per cycle carrying a write.
  always @(negedge Clk) begin
    WbEntry e;
    if (Reset_n) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("regwrite", RegWrite, 1);
        check("write_register", WriteRegister, e.r);
        check("write_data", WriteData, e.d);
        $display("wr r%0d = %08h (count=%0d)", WriteRegister, WriteData, Count);
        lastR = e.r; lastD = e.d; curValid = 1;
      end else begin
        check("regwrite_idle", RegWrite, 0);
        check("hold_register", WriteRegister, lastR);
        check("hold_data", WriteData, lastD);
        curValid = 0;
      end
      check("count", Count, modelQ.size());
      check("empty", Empty, modelQ.size() == 0);
      check("full", Full, modelQ.size() == DEPTH);
      check("req_ready", ReqReady, modelQ.size() < DEPTH);
      check("pri_stall", PriStall, (starve == STARVE_LIMIT) && (modelQ.size() > 0));
`ifdef WB_FORWARD_EN
      lookupCheck("lookup1", LookupRegister1, LookupHit1, LookupData1);
      lookupCheck("lookup2", LookupRegister2, LookupHit2, LookupData2);
`endif
    end
  end

`ifdef WB_FORWARD_EN
  task automatic lookupCheck(input string name, input logic [4:0] key,
                             input logic hitAct, input logic [31:0] dataAct);
    bit          hit;
    logic [31:0] data;
    hit = 0; data = '0;
    if (key != 5'd0) begin
      if (curValid && lastR == key) begin hit = 1; data = lastD; end
      foreach (modelQ[i]) if (modelQ[i].r == key) begin hit = 1; data = modelQ[i].d; end
    end
    check({name, "_hit"}, hitAct, hit);
    if (hit) check({name, "_data"}, dataAct, data);
  endtask
`endif

  // ---------------- stimulus ----------------
  task automatic drive(input bit pw, input logic [4:0] pr, input logic [31:0] pd,
                       input bit rv, input logic [4:0] rr, input logic [31:0] rd);
    PriRegWrite = pw; PriWriteRegister = pr; PriWriteData = pd;
    ReqValid = rv; ReqRegister = rr; ReqData = rd;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_regwrite", RegWrite, 0);
    check("rst_write_register", WriteRegister, 0);
    check("rst_write_data", WriteData, 0);
    check("rst_count", Count, 0);
    check("rst_empty", Empty, 1);
    check("rst_pristall", PriStall, 0);
    Reset_n = 1'b1;
    idle(2);

    // x0 push is accepted but never stored or written.
    check("x0_ready", ReqReady, 1);
    drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
    idle(3);

    // Primary and queue head collide below the starve limit: primary first.
    drive(0, 0, 0, 1, 5'd9, 32'h99);
    drive(1, 5'd3, 32'hAA, 0, 0, 0);
    idle(3);

    // Fill the queue under continuous primary traffic to force stalls.
    for (int i = 1; i <= 4; i++)
      drive(1, 5'(20 + i), 32'h1000 + i, 1, 5'(i), 32'h100 + i);
    check("fill_full", Full, 1);
    check("fill_ready", ReqReady, 0);
    for (int i = 0; i < 40; i++) drive(1, 5'(24 + i % 7), 32'h2000 + i, 0, 0, 0);
    idle(6);

    // Push/pop together at Count=2; pointers wrap and order holds r1..r7.
    drive(1, 5'd30, 32'h3001, 1, 5'd1, 32'h11);
    drive(1, 5'd30, 32'h3002, 1, 5'd2, 32'h22);
    for (int i = 3; i <= 6; i++) drive(0, 0, 0, 1, 5'(i), 32'h11 * i);
    drive(0, 0, 0, 1, 5'd7, 32'h77);
    check("wrap_count", Count, 2);
    idle(4);

    // Asynchronous reset mid-traffic with three entries queued.
    for (int i = 1; i <= 3; i++) drive(1, 5'd12, 32'h4000 + i, 1, 5'(10 + i), 32'h500 + i);
    check("pre_reset_count", Count, 3);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_count", Count, 0);
    check("async_empty", Empty, 1);
    check("async_regwrite", RegWrite, 0);
    modelReset();
    PriRegWrite = 0; ReqValid = 0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    drive(0, 0, 0, 1, 5'd5, 32'h11);
    idle(3);

`ifdef WB_FORWARD_EN
    drive(1, 5'd8, 32'h8, 1, 5'd4, 32'h1);
    drive(1, 5'd8, 32'h9, 1, 5'd4, 32'h2);
    LookupRegister1 = 5'd4; LookupRegister2 = 5'd0;
    #2;
    check("fwd_hit1", LookupHit1, 1);
    check("fwd_data1", LookupData1, 32'h2);
    check("fwd_hit2", LookupHit2, 0);
    idle(4);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
`ifdef WB_FORWARD_EN
      LookupRegister1 = 5'($urandom_range(0, 7));
      LookupRegister2 = 5'($urandom_range(0, 31));
`endif
      drive($urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
